alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for a shared combinational ALU with a single-entry response register.
// Optional round-robin arbitration when ALU_ARB_RR_EN is defined; fixed priority to requester 0 otherwise.
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_r0_valid,
    input  logic [31:0] i_r0_operand_a,
    input  logic [31:0] i_r0_operand_b,
    input  logic [3:0]  i_r0_alu_op,
    output logic        o_r0_ready,
    input  logic        i_r1_valid,
    input  logic [31:0] i_r1_operand_a,
    input  logic [31:0] i_r1_operand_b,
    input  logic [3:0]  i_r1_alu_op,
    output logic        o_r1_ready,
    output logic [31:0] o_alu_operand_a,
    output logic [31:0] o_alu_operand_b,
    output logic [3:0]  o_alu_op,
    input  logic [31:0] i_alu_data,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id,
    output logic        o_rsp_err,
    input  logic        i_rsp_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;

    logic        can_issue;
    logic        favour_r0;
    logic        grant0, grant1, grant_any;

`ifdef ALU_ARB_RR_EN
    // ptr_q == 0 favours requester 0; after a grant it points at the other requester.
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = grant0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign favour_r0 = ~ptr_q;
`else
    assign favour_r0 = 1'b1;
`endif

    // Issue is allowed when the buffer is free or is being drained this same cycle.
    assign can_issue = ~i_reset & ((state_q == EMPTY) | i_rsp_ready);
    assign grant0    = can_issue & i_r0_valid & (~i_r1_valid | favour_r0);
    assign grant1    = can_issue & i_r1_valid & ~grant0;
    assign grant_any = grant0 | grant1;

    assign o_r0_ready = grant0;
    assign o_r1_ready = grant1;

    assign o_alu_operand_a = grant1 ? i_r1_operand_a : i_r0_operand_a;
    assign o_alu_operand_b = grant1 ? i_r1_operand_b : i_r0_operand_b;
    assign o_alu_op        = grant1 ? i_r1_alu_op    : i_r0_alu_op;

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        if (grant_any) begin
            state_d    = FULL;
            rsp_data_d = i_alu_data;
            rsp_id_d   = grant1;
            rsp_err_d  = (o_alu_op > 4'd9);
        end else if ((state_q == FULL) && i_rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= EMPTY;
            rsp_data_q <= 32'd0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_rsp_valid = (state_q == FULL);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_r0_valid, i_r1_valid;
    logic [31:0] i_r0_operand_a, i_r0_operand_b, i_r1_operand_a, i_r1_operand_b;
    logic [3:0]  i_r0_alu_op, i_r1_alu_op;
    logic        o_r0_ready, o_r1_ready;
    logic [31:0] o_alu_operand_a, o_alu_operand_b;
    logic [3:0]  o_alu_op;
    logic [31:0] i_alu_data;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_id, o_rsp_err;
    logic        i_rsp_ready;

    int n_chk  = 0;
    int n_pass = 0;

    alu_arbiter dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_r0_valid      (i_r0_valid),
        .i_r0_operand_a  (i_r0_operand_a),
        .i_r0_operand_b  (i_r0_operand_b),
        .i_r0_alu_op     (i_r0_alu_op),
        .o_r0_ready      (o_r0_ready),
        .i_r1_valid      (i_r1_valid),
        .i_r1_operand_a  (i_r1_operand_a),
        .i_r1_operand_b  (i_r1_operand_b),
        .i_r1_alu_op     (i_r1_alu_op),
        .o_r1_ready      (o_r1_ready),
        .o_alu_operand_a (o_alu_operand_a),
        .o_alu_operand_b (o_alu_operand_b),
        .o_alu_op        (o_alu_op),
        .i_alu_data      (i_alu_data),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_id        (o_rsp_id),
        .o_rsp_err       (o_rsp_err),
        .i_rsp_ready     (i_rsp_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a | b;
            4'd6:    return a & b;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // Shared combinational ALU seen by the arbiter.
    always_comb i_alu_data = alu_ref(o_alu_op, o_alu_operand_a, o_alu_operand_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic rr);
        i_r0_valid = v0; i_r0_alu_op = op0; i_r0_operand_a = a0; i_r0_operand_b = b0;
        i_r1_valid = v1; i_r1_alu_op = op1; i_r1_operand_a = a1; i_r1_operand_b = b1;
        i_rsp_ready = rr;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        set_in(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    typedef struct {
        logic        v0;
        logic [3:0]  op0;
        logic [31:0] a0, b0;
        logic        v1;
        logic [3:0]  op1;
        logic [31:0] a1, b1;
        logic        rr;
        logic        e_r0, e_r1, e_vld;
        logic [31:0] e_data;
        logic        e_id, e_err;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic rr, input logic e_r0, input logic e_r1, input logic e_vld,
                                input logic [31:0] e_data, input logic e_id, input logic e_err);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_vld = e_vld;
        v.e_data = e_data; v.e_id = e_id; v.e_err = e_err;
        return v;
    endfunction

    vec_t tbl[12];

    // Reference model state: one buffered response plus the currently favoured requester.
    logic        m_full, m_id, m_err, m_clean;
    logic [31:0] m_data;
    int          m_fav;

    initial begin
        int win;
        logic exp_r0, exp_r1;
        logic rst_now, can;

        i_reset = 1'b1;
        set_in(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b0);

        // Reset state
        @(negedge i_clk);
        i_r0_valid = 1'b1; i_r1_valid = 1'b1; i_rsp_ready = 1'b1;
        #1;
        chk("rst_r0_ready", o_r0_ready, 0);
        chk("rst_r1_ready", o_r1_ready, 0);
        @(posedge i_clk); #1;
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_id", o_rsp_id, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        do_reset();

        // Directed table: single requester at a time, walking every opcode class
        tbl[0]  = mk(1, 4'd0, 32'd5, 32'd7,                 0, 4'd0, 0, 0,                         1, 1, 0, 1, 32'd12,         0, 0);
        tbl[1]  = mk(0, 4'd0, 0, 0,                         1, 4'd1, 32'd3, 32'd5,                 0, 0, 0, 1, 32'd12,         0, 0);
        tbl[2]  = mk(0, 4'd0, 0, 0,                         1, 4'd1, 32'd3, 32'd5,                 1, 0, 1, 1, 32'hFFFFFFFE,   1, 0);
        tbl[3]  = mk(1, 4'hC, 32'd1, 32'd2,                 0, 4'd0, 0, 0,                         1, 1, 0, 1, 32'd0,          0, 1);
        tbl[4]  = mk(0, 4'd0, 0, 0,                         0, 4'd0, 0, 0,                         1, 0, 0, 0, 32'd0,          0, 1);
        tbl[5]  = mk(1, 4'd2, 32'hFFFFFFFF, 32'd1,          0, 4'd0, 0, 0,                         0, 1, 0, 1, 32'd1,          0, 0);
        tbl[6]  = mk(0, 4'd0, 0, 0,                         1, 4'd3, 32'hFFFFFFFF, 32'd1,          0, 0, 0, 1, 32'd1,          0, 0);
        tbl[7]  = mk(0, 4'd0, 0, 0,                         1, 4'd3, 32'hFFFFFFFF, 32'd1,          1, 0, 1, 1, 32'd0,          1, 0);
        tbl[8]  = mk(1, 4'd9, 32'h80000000, 32'd4,          0, 4'd0, 0, 0,                         1, 1, 0, 1, 32'hF8000000,   0, 0);
        tbl[9]  = mk(0, 4'd0, 0, 0,                         1, 4'd7, 32'd1, 32'd31,                1, 0, 1, 1, 32'h80000000,   1, 0);
        tbl[10] = mk(1, 4'd8, 32'h80000000, 32'd4,          0, 4'd0, 0, 0,                         1, 1, 0, 1, 32'h08000000,   0, 0);
        tbl[11] = mk(1, 4'd6, 32'h0000F0F0, 32'h00000FF0,   1'b0, 4'd5, 0, 0,                      1, 1, 0, 1, 32'h000000F0,   0, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            set_in(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
            #1;
            chk($sformatf("tbl%0d_r0_ready", i), o_r0_ready, tbl[i].e_r0);
            chk($sformatf("tbl%0d_r1_ready", i), o_r1_ready, tbl[i].e_r1);
            @(posedge i_clk); #1;
            chk($sformatf("tbl%0d_rsp_valid", i), o_rsp_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_rsp_data", i), o_rsp_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_rsp_id", i), o_rsp_id, tbl[i].e_id);
                chk($sformatf("tbl%0d_rsp_err", i), o_rsp_err, tbl[i].e_err);
            end
        end

        // Continuous contention with the consumer always ready
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int w;
`ifdef ALU_ARB_RR_EN
            w = k % 2;
`else
            w = 0;
`endif
            @(negedge i_clk);
            set_in(1, 4'd0, 32'd10, 32'd1, 1, 4'd4, 32'd10, 32'd3, 1);
            #1;
            chk($sformatf("cont%0d_r0_ready", k), o_r0_ready, (w == 0));
            chk($sformatf("cont%0d_r1_ready", k), o_r1_ready, (w == 1));
            @(posedge i_clk); #1;
            chk($sformatf("cont%0d_rsp_valid", k), o_rsp_valid, 1);
            chk($sformatf("cont%0d_rsp_id", k), o_rsp_id, w);
            chk($sformatf("cont%0d_rsp_data", k), o_rsp_data, (w == 1) ? 32'd9 : 32'd11);
        end

        // Held response under backpressure, then same-cycle reissue on drain
        do_reset();
        @(negedge i_clk);
        set_in(0, 4'd0, 0, 0, 1, 4'd1, 32'd3, 32'd5, 1);
        @(negedge i_clk);
        set_in(1, 4'd0, 32'd2, 32'd2, 0, 4'd0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d_r0_ready", k), o_r0_ready, 0);
            chk($sformatf("hold%0d_r1_ready", k), o_r1_ready, 0);
            chk($sformatf("hold%0d_rsp_valid", k), o_rsp_valid, 1);
            chk($sformatf("hold%0d_rsp_data", k), o_rsp_data, 32'hFFFFFFFE);
            chk($sformatf("hold%0d_rsp_id", k), o_rsp_id, 1);
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b1;
        #1;
        chk("drain_r0_ready", o_r0_ready, 1);
        @(posedge i_clk); #1;
        chk("drain_rsp_data", o_rsp_data, 32'd4);
        chk("drain_rsp_id", o_rsp_id, 0);

        // Reset pulse while a response is held, then contention restarts at requester 0
        do_reset();
        @(negedge i_clk);
        set_in(1, 4'd0, 32'd1, 32'd1, 0, 4'd0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        set_in(1, 4'd0, 32'd1, 32'd1, 1, 4'd0, 32'd2, 32'd2, 1);
        #1;
        chk("mid_rst_r0_ready", o_r0_ready, 0);
        chk("mid_rst_r1_ready", o_r1_ready, 0);
        @(posedge i_clk); #1;
        chk("mid_rst_rsp_valid", o_rsp_valid, 0);
        chk("mid_rst_rsp_data", o_rsp_data, 0);
        chk("mid_rst_rsp_id", o_rsp_id, 0);
        chk("mid_rst_rsp_err", o_rsp_err, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("post_rst_r0_ready", o_r0_ready, 1);
        chk("post_rst_r1_ready", o_r1_ready, 0);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            rst_now = (i == 0) || ($urandom_range(0, 99) < 2);
            i_reset = rst_now;
            set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                   $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                   $urandom_range(0, 2) != 0);
            can = !rst_now && (!m_full || i_rsp_ready);
            if (!can) win = -1;
            else if (i_r0_valid && i_r1_valid) begin
`ifdef ALU_ARB_RR_EN
                win = m_fav;
`else
                win = 0;
`endif
            end
            else if (i_r0_valid) win = 0;
            else if (i_r1_valid) win = 1;
            else win = -1;
            exp_r0 = (win == 0);
            exp_r1 = (win == 1);
            #1;
            chk("rnd_r0_ready", o_r0_ready, exp_r0);
            chk("rnd_r1_ready", o_r1_ready, exp_r1);
            chk("rnd_alu_op", o_alu_op, (win == 1) ? i_r1_alu_op : i_r0_alu_op);
            chk("rnd_alu_a", o_alu_operand_a, (win == 1) ? i_r1_operand_a : i_r0_operand_a);
            chk("rnd_alu_b", o_alu_operand_b, (win == 1) ? i_r1_operand_b : i_r0_operand_b);
            if (i > 0) begin
                chk("rnd_rsp_valid", o_rsp_valid, m_full);
                if (m_full || m_clean) begin
                    chk("rnd_rsp_data", o_rsp_data, m_data);
                    chk("rnd_rsp_id", o_rsp_id, m_id);
                    chk("rnd_rsp_err", o_rsp_err, m_err);
                end
            end
            @(posedge i_clk);
            if (rst_now) begin
                m_full = 0; m_data = 0; m_id = 0; m_err = 0; m_fav = 0; m_clean = 1;
            end else if (win >= 0) begin
                m_full  = 1;
                m_data  = (win == 1) ? alu_ref(i_r1_alu_op, i_r1_operand_a, i_r1_operand_b)
                                     : alu_ref(i_r0_alu_op, i_r0_operand_a, i_r0_operand_b);
                m_err   = ((win == 1) ? i_r1_alu_op : i_r0_alu_op) > 4'd9;
                m_id    = (win == 1);
                m_fav   = 1 - win;
                m_clean = 0;
            end else if (m_full && i_rsp_ready) begin
                m_full  = 0;
                m_clean = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
